// File: rtl/fib_rr_arbiter.sv
// Round-robin arbiter that lends a single Fibonacci unit (soc/eoc) to two requesters.
// Operands and results each use a dav_/rfd handshake, and one computation is in flight at a time.
module fib_rr_arbiter #(
  parameter int W_N = 8,
  parameter int W_F = 32
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           dav_req0_,
  input  logic [W_N-1:0] n0,
  output logic           rfd_req0,
  input  logic           dav_req1_,
  input  logic [W_N-1:0] n1,
  output logic           rfd_req1,
  output logic [W_F-1:0] out0,
  output logic           dav_out0_,
  input  logic           rfd_out0,
  output logic [W_F-1:0] out1,
  output logic           dav_out1_,
  input  logic           rfd_out1,
  output logic           soc,
  input  logic           eoc,
  output logic [W_N-1:0] n_u,
  input  logic [W_F-1:0] f_u
);

  typedef enum logic [2:0] {
    S_ARB  = 3'd0,
    S_WDAV = 3'd1,
    S_WSOC = 3'd2,
    S_WEOC = 3'd3,
    S_OUT  = 3'd4,
    S_OUTR = 3'd5
  } state_t;

  state_t         state_q, state_d;
  logic           owner_q, owner_d;
  logic           last_q, last_d;
  logic           soc_q, soc_d;
  logic [W_N-1:0] n_u_q, n_u_d;
  logic [1:0]     rfd_req_q, rfd_req_d;
  logic [1:0]     dav_out_q, dav_out_d;
  logic [W_F-1:0] out0_q, out0_d;
  logic [W_F-1:0] out1_q, out1_d;

  logic grant_s;
  logic owner_dav_s;
  logic owner_rfd_out_s;

  // Tie goes to the requester that did not win last time.
  always_comb begin
    grant_s = 1'b0;
    if (!dav_req0_ && !dav_req1_) begin
      grant_s = ~last_q;
    end else if (!dav_req1_) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  assign owner_dav_s     = owner_q ? dav_req1_ : dav_req0_;
  assign owner_rfd_out_s = owner_q ? rfd_out1 : rfd_out0;

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    soc_d     = soc_q;
    n_u_d     = n_u_q;
    rfd_req_d = rfd_req_q;
    dav_out_d = dav_out_q;
    out0_d    = out0_q;
    out1_d    = out1_q;
    case (state_q)
      S_ARB: begin
        if (!dav_req0_ || !dav_req1_) begin
          owner_d            = grant_s;
          last_d             = grant_s;
          n_u_d              = grant_s ? n1 : n0;
          rfd_req_d[grant_s] = 1'b0;
          state_d            = S_WDAV;
        end else begin
          state_d = S_ARB;
        end
      end
      S_WDAV: begin
        if (owner_dav_s) begin
          rfd_req_d[owner_q] = 1'b1;
          soc_d              = 1'b1;
          state_d            = S_WSOC;
        end else begin
          state_d = S_WDAV;
        end
      end
      S_WSOC: begin
        if (!eoc) begin
          soc_d   = 1'b0;
          state_d = S_WEOC;
        end else begin
          state_d = S_WSOC;
        end
      end
      S_WEOC: begin
        if (eoc) begin
          if (owner_q) begin
            out1_d = f_u;
          end else begin
            out0_d = f_u;
          end
          state_d = S_OUT;
        end else begin
          state_d = S_WEOC;
        end
      end
      S_OUT: begin
        // dav_out_ is still high only in the entry cycle, so the consumer's rfd is looked at from the next cycle.
        if (dav_out_q[owner_q]) begin
          dav_out_d[owner_q] = 1'b0;
        end else if (!owner_rfd_out_s) begin
          dav_out_d[owner_q] = 1'b1;
          state_d            = S_OUTR;
        end else begin
          state_d = S_OUT;
        end
      end
      S_OUTR: begin
        if (owner_rfd_out_s) begin
          state_d = S_ARB;
        end else begin
          state_d = S_OUTR;
        end
      end
      default: begin
        state_d = S_ARB;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_ARB;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      soc_q     <= 1'b0;
      n_u_q     <= {W_N{1'b0}};
      rfd_req_q <= 2'b11;
      dav_out_q <= 2'b11;
      out0_q    <= {W_F{1'b0}};
      out1_q    <= {W_F{1'b0}};
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      soc_q     <= soc_d;
      n_u_q     <= n_u_d;
      rfd_req_q <= rfd_req_d;
      dav_out_q <= dav_out_d;
      out0_q    <= out0_d;
      out1_q    <= out1_d;
    end
  end

  assign rfd_req0  = rfd_req_q[0];
  assign rfd_req1  = rfd_req_q[1];
  assign dav_out0_ = dav_out_q[0];
  assign dav_out1_ = dav_out_q[1];
  assign out0      = out0_q;
  assign out1      = out1_q;
  assign soc       = soc_q;
  assign n_u       = n_u_q;

endmodule

// File: tb/tb_fib_rr_arbiter.sv
// Directed bench for fib_rr_arbiter: a behavioural Fibonacci unit, single-request vector table,
// and hand-written sequences for the tie, alternation, slow-consumer and mid-run reset cases.
module tb_fib_rr_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        dav_req0_ = 1'b1, dav_req1_ = 1'b1;
  logic [7:0]  n0 = 8'd0, n1 = 8'd0;
  logic        rfd_req0, rfd_req1;
  logic [31:0] out0, out1;
  logic        dav_out0_, dav_out1_;
  logic        rfd_out0 = 1'b1, rfd_out1 = 1'b1;
  logic        soc;
  logic        eoc;
  logic [7:0]  n_u;
  logic [31:0] f_u;

  int n_checks = 0;
  int n_fail   = 0;
  int unit_lat = 3;
  int busy_cnt;
  logic [7:0] n_lat;
  int grants[$];

  typedef struct {
    int          k;
    logic [7:0]  n;
    logic [31:0] exp;
    bit          early;
  } vec_t;
  vec_t vecs[6];

  fib_rr_arbiter #(.W_N(8), .W_F(32)) dut (
    .clock(clock), .reset(reset),
    .dav_req0_(dav_req0_), .n0(n0), .rfd_req0(rfd_req0),
    .dav_req1_(dav_req1_), .n1(n1), .rfd_req1(rfd_req1),
    .out0(out0), .dav_out0_(dav_out0_), .rfd_out0(rfd_out0),
    .out1(out1), .dav_out1_(dav_out1_), .rfd_out1(rfd_out1),
    .soc(soc), .eoc(eoc), .n_u(n_u), .f_u(f_u)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] fib(input int n);
    logic [31:0] a, b, t;
    a = 32'd0;
    b = 32'd1;
    for (int i = 0; i < n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Behavioural Fibonacci unit: eoc=1 idle, drops on soc, returns after unit_lat clocks.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      eoc      <= 1'b1;
      f_u      <= 32'd0;
      busy_cnt <= 0;
      n_lat    <= 8'd0;
    end else if (eoc && soc) begin
      eoc      <= 1'b0;
      busy_cnt <= unit_lat;
      n_lat    <= n_u;
    end else if (!eoc) begin
      if (busy_cnt <= 1) begin
        eoc <= 1'b1;
        f_u <= fib(int'(n_lat));
      end else begin
        busy_cnt <= busy_cnt - 1;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic sig_of(input int sel);
    case (sel)
      0:       return rfd_req0;
      1:       return rfd_req1;
      2:       return dav_out0_;
      3:       return dav_out1_;
      4:       return soc;
      default: return eoc;
    endcase
  endfunction

  task automatic wait_for(input int sel, input logic val, input string name);
    int i;
    i = 0;
    while (sig_of(sel) !== val && i < 200) begin
      @(negedge clock);
      i++;
    end
    chk(name, sig_of(sel), val);
  endtask

  task automatic set_rfd_out(input int k, input logic v);
    if (k == 0) rfd_out0 = v;
    else        rfd_out1 = v;
  endtask

  task automatic request(input int k, input logic [7:0] n);
    if (k == 0) begin n0 = n; dav_req0_ = 1'b0; end
    else        begin n1 = n; dav_req1_ = 1'b0; end
    wait_for(k, 1'b0, "grant");
    if (k == 0) dav_req0_ = 1'b1;
    else        dav_req1_ = 1'b1;
  endtask

  task automatic consume(input int k, input logic [31:0] exp, input int delay, input bit early);
    if (early) set_rfd_out(k, 1'b0);
    wait_for(2 + k, 1'b0, "dav_out_fall");
    chk("result", (k == 0) ? out0 : out1, exp);
    chk("other_dav_out_idle", sig_of(3 - k), 1'b1);
    if (early) begin
      @(negedge clock);
      chk("early_rfd_one_cycle", sig_of(2 + k), 1'b1);
    end else begin
      repeat (delay) @(negedge clock);
      set_rfd_out(k, 1'b0);
      wait_for(2 + k, 1'b1, "dav_out_rise");
    end
    set_rfd_out(k, 1'b1);
  endtask

  task automatic pulse_reset(input bit check);
    @(negedge clock);
    #1 reset = 1'b1;
    #3;
    if (check) begin
      chk("rst_soc", soc, 1'b0);
      chk("rst_rfd_req0", rfd_req0, 1'b1);
      chk("rst_rfd_req1", rfd_req1, 1'b1);
      chk("rst_dav_out0", dav_out0_, 1'b1);
      chk("rst_dav_out1", dav_out1_, 1'b1);
      chk("rst_out0", out0, 32'd0);
      chk("rst_out1", out1, 32'd0);
      chk("rst_n_u", n_u, 8'd0);
    end
    #2 reset = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{k: 1, n: 8'd0,  exp: 32'h0000_0000, early: 1'b0};
    vecs[1] = '{k: 0, n: 8'd1,  exp: 32'h0000_0001, early: 1'b1};
    vecs[2] = '{k: 1, n: 8'd13, exp: 32'h0000_00E9, early: 1'b1};
    vecs[3] = '{k: 0, n: 8'd47, exp: 32'hB119_24E1, early: 1'b0};
    vecs[4] = '{k: 0, n: 8'd2,  exp: 32'h0000_0001, early: 1'b0};
    vecs[5] = '{k: 1, n: 8'd40, exp: 32'h0619_7ECB, early: 1'b1};

    // Reset state.
    pulse_reset(1'b1);

    // Single request from requester 0.
    request(0, 8'd10);
    wait_for(4, 1'b1, "soc_rise");
    chk("n_u_single", n_u, 8'd10);
    wait_for(4, 1'b0, "soc_fall");
    consume(0, 32'h0000_0037, 0, 1'b0);

    // Tie from a fresh reset: requester 0 first.
    pulse_reset(1'b0);
    grants.delete();
    fork
      begin request(0, 8'd5); grants.push_back(0); consume(0, 32'h0000_0005, 0, 1'b0); end
      begin request(1, 8'd6); grants.push_back(1); consume(1, 32'h0000_0008, 0, 1'b0); end
    join
    chk("tie_grant_count", grants.size(), 2);
    if (grants.size() == 2) begin
      chk("tie_first", grants[0], 0);
      chk("tie_second", grants[1], 1);
    end

    // Table of single requests, some with the result port already ready.
    for (int i = 0; i < 6; i++) begin
      request(vecs[i].k, vecs[i].n);
      consume(vecs[i].k, vecs[i].exp, 0, vecs[i].early);
    end

    // Both requesters continuously busy: grants alternate.
    grants.delete();
    fork
      for (int a = 2; a <= 40; a++) begin
        request(0, a[7:0]); grants.push_back(0); consume(0, fib(a), 0, 1'b0);
      end
      for (int b = 2; b <= 40; b++) begin
        request(1, b[7:0]); grants.push_back(1); consume(1, fib(b), 0, 1'b0);
      end
    join
    chk("alt_grant_count", grants.size(), 78);
    for (int i = 1; i < grants.size(); i++) begin
      if (grants[i] == grants[i-1]) chk("alt_strict", grants[i], 1 - grants[i-1]);
    end

    // Slow consumer on port 1 while requester 0 waits.
    request(1, 8'd9);
    n0 = 8'd7;
    dav_req0_ = 1'b0;
    wait_for(3, 1'b0, "slow_dav_out1_fall");
    chk("slow_out1", out1, 32'h0000_0022);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("slow_no_soc", soc, 1'b0);
      chk("slow_rfd_req0_held", rfd_req0, 1'b1);
      chk("slow_dav_out1_held", dav_out1_, 1'b0);
    end
    rfd_out1 = 1'b0;
    wait_for(3, 1'b1, "slow_dav_out1_rise");
    repeat (2) begin
      @(negedge clock);
      chk("outr_no_grant", rfd_req0, 1'b1);
    end
    rfd_out1 = 1'b1;
    wait_for(0, 1'b0, "slow_req0_grant");
    dav_req0_ = 1'b1;
    consume(0, 32'h0000_000D, 0, 1'b0);

    // Reset while the unit is computing; the in-flight result is discarded.
    unit_lat = 8;
    request(0, 8'd30);
    wait_for(4, 1'b1, "rst_run_soc_rise");
    wait_for(4, 1'b0, "rst_run_in_weoc");
    pulse_reset(1'b1);
    unit_lat = 3;
    request(1, 8'd20);
    consume(1, 32'h0000_1A6D, 0, 1'b0);
    chk("rst_run_dav_out0_idle", dav_out0_, 1'b1);
    chk("rst_run_out0_cleared", out0, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
